// File: rtl/bcd_pkg.sv
// Shared BCD digit width, segment constants and the BCD to seven-segment encoder.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b000_0000;

    // Segment order a..g maps to bits 6..0, active-high.
    function automatic logic [SEG_W-1:0] seg7(input logic [BCD_W-1:0] bcd);
        logic [SEG_W-1:0] s;
        s = SEG_BLANK;
        case (bcd)
            4'd0:    s = 7'b111_1110;
            4'd1:    s = 7'b011_0000;
            4'd2:    s = 7'b110_1101;
            4'd3:    s = 7'b111_1001;
            4'd4:    s = 7'b011_0011;
            4'd5:    s = 7'b101_1011;
            4'd6:    s = 7'b101_1111;
            4'd7:    s = 7'b111_0000;
            4'd8:    s = 7'b111_1111;
            4'd9:    s = 7'b111_1011;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register; steps only when every lower digit is at its rollover value.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    input  logic             carry_in,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] digit,
    output logic             all9,
    output logic             all0
);

    logic [BCD_W-1:0] digit_next;

    // carry_in/borrow_in mean "all lower digits are 9 / 0"; extend the chain through this digit.
    always_comb begin
        all9 = carry_in  && (digit == BCD_W'(9));
        all0 = borrow_in && (digit == BCD_W'(0));
    end

    always_comb begin
        digit_next = digit;
        if (load) begin
            digit_next = (load_val > BCD_W'(9)) ? BCD_W'(0) : load_val;
        end else if (inc && carry_in) begin
            digit_next = (digit == BCD_W'(9)) ? BCD_W'(0) : digit + BCD_W'(1);
        end else if (dec && borrow_in) begin
            digit_next = (digit == BCD_W'(0)) ? BCD_W'(9) : digit - BCD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= '0;
        end else begin
            digit <= digit_next;
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with parallel load, wrap/load-error pulses and
// registered seven-segment outputs trailing count by one cycle.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter bit          LZB    = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enb,
    input  logic                    up,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                    wrap,
    output logic                    load_err,
    output logic [SEG_W*DIGITS-1:0] seg
);

    localparam int unsigned CNT_W = BCD_W * DIGITS;
    localparam int unsigned SEG_TW = SEG_W * DIGITS;

    logic [DIGITS:0]   carry;
    logic [DIGITS:0]   borrow;
    logic [DIGITS-1:0] all9;
    logic [DIGITS-1:0] all0;
    logic              inc_c;
    logic              dec_c;
    logic              bad_load_c;
    logic              wrap_c;

    always_comb begin
        inc_c = enb && up;
        dec_c = enb && !up;
    end

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .rst       (rst),
            .load      (load),
            .load_val  (load_val[g*BCD_W +: BCD_W]),
            .inc       (inc_c),
            .dec       (dec_c),
            .carry_in  (carry[g]),
            .borrow_in (borrow[g]),
            .digit     (count[g*BCD_W +: BCD_W]),
            .all9      (all9[g]),
            .all0      (all0[g])
        );
        assign carry[g+1]  = all9[g];
        assign borrow[g+1] = all0[g];
    end

    always_comb begin
        bad_load_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_val[i*BCD_W +: BCD_W] > BCD_W'(9)) begin
                bad_load_c = 1'b1;
            end
        end
        wrap_c = !load && enb && (up ? carry[DIGITS] : borrow[DIGITS]);
    end

    // Leading-zero blanking scans from the most significant digit down; digit 0 always shows.
    function automatic logic [SEG_TW-1:0] render(input logic [CNT_W-1:0] value);
        logic [SEG_TW-1:0] s;
        logic [BCD_W-1:0]  d;
        logic              lead;
        s    = '0;
        lead = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            d    = value[i*BCD_W +: BCD_W];
            lead = lead && (d == BCD_W'(0));
            if (LZB && (i != 0) && lead) begin
                s[i*SEG_W +: SEG_W] = SEG_BLANK;
            end else begin
                s[i*SEG_W +: SEG_W] = seg7(d);
            end
        end
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
            seg      <= render('0);
        end else begin
            wrap     <= wrap_c;
            load_err <= load && bad_load_c;
            seg      <= render(count);
        end
    end

endmodule
